// File: rtl/mlp_98_frame_feeder_if.sv
// Stream-side handshake bundle for the mlp_98 frame feeder: sample input and result output.
interface mlp_98_frame_feeder_if #(
   parameter int unsigned W_X = 4,
   parameter int unsigned W_Y = 23
) ();

   logic           s_valid;
   logic           s_ready;
   logic [W_X-1:0] s_mag;
   logic           s_pol;
   logic           s_last;

   logic           m_valid;
   logic           m_ready;
   logic [W_Y-1:0] m_data;

   // Producer of samples / consumer of results.
   modport master (
      output s_valid,
      output s_mag,
      output s_pol,
      output s_last,
      input  s_ready,
      input  m_valid,
      input  m_data,
      output m_ready
   );

   // The feeder itself.
   modport slave (
      input  s_valid,
      input  s_mag,
      input  s_pol,
      input  s_last,
      output s_ready,
      output m_valid,
      output m_data,
      input  m_ready
   );

endinterface

// File: rtl/mlp_98_frame_feeder.sv
// Packs a serial sign-magnitude sample stream into the mlp_98 input frame, holds it while the
// core settles, then captures the core result and offers it on a valid/ready output.
module mlp_98_frame_feeder #(
   parameter int unsigned N1      = 98,
   parameter int unsigned W_X     = 4,
   parameter int unsigned W_Y     = 23,
   parameter int unsigned LATENCY = 11
) (
   input  logic                     clk,
   input  logic                     rstn,
   mlp_98_frame_feeder_if.slave     bus,
   output logic [(N1/2)*W_X-1:0]    in_mag,
   output logic [N1/2-1:0]          in_pol,
   input  logic [W_Y-1:0]           mlp_out,
   output logic                     err
);

   localparam int unsigned NS = N1 / 2;
   localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {StFill, StWait, StOut} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [WW-1:0]       wait_q, wait_d;
   logic [NS*W_X-1:0]   mag_q, mag_d;
   logic [NS-1:0]       pol_q, pol_d;
   logic                m_valid_q, m_valid_d;
   logic [W_Y-1:0]      m_data_q, m_data_d;
   logic                err_q, err_d;

   logic                fill;
   logic                accept;
   logic                last_lane;

   assign fill      = (state_q == StFill);
   assign accept    = bus.s_valid && fill;
   assign last_lane = (count_q == CW'(NS - 1));

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wait_d    = wait_q;
      mag_d     = mag_q;
      pol_d     = pol_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      err_d     = 1'b0;

      case (state_q)
         StFill: begin
            if (accept) begin
               mag_d[count_q*W_X +: W_X] = bus.s_mag;
               pol_d[count_q]            = bus.s_pol;
               if (last_lane) begin
                  // A full frame is always used; a missing s_last only raises err.
                  state_d = StWait;
                  count_d = '0;
                  wait_d  = WW'(LATENCY - 1);
                  err_d   = !bus.s_last;
               end else if (bus.s_last) begin
                  // Early termination: the partial frame is dropped, lanes are left as written.
                  count_d = '0;
                  err_d   = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end

         StWait: begin
            if (wait_q == '0) begin
               m_data_d  = mlp_out;
               m_valid_d = 1'b1;
               state_d   = StOut;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end

         StOut: begin
            if (m_valid_q && bus.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = StFill;
            end
         end

         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StFill;
         count_q   <= '0;
         wait_q    <= '0;
         mag_q     <= '0;
         pol_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wait_q    <= wait_d;
         mag_q     <= mag_d;
         pol_q     <= pol_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end

   // s_ready is gated by rstn so it reads low for the whole reset interval.
   assign bus.s_ready = rstn && fill;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign in_mag      = mag_q;
   assign in_pol      = pol_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mlp_98_frame_feeder.sv
// Directed bench for mlp_98_frame_feeder: framing, latency, backpressure, gaps and mid-WAIT reset.
module tb_mlp_98_frame_feeder;

   localparam int unsigned N1  = 98;
   localparam int unsigned NS  = 49;
   localparam int unsigned W_X = 4;
   localparam int unsigned W_Y = 23;
   localparam int unsigned LAT = 11;

   logic               clk  = 1'b0;
   logic               rstn = 1'b1;
   logic [NS*W_X-1:0]  in_mag;
   logic [NS-1:0]      in_pol;
   logic [W_Y-1:0]     mlp_out;
   logic               err;

   always #5 clk = ~clk;

   mlp_98_frame_feeder_if #(.W_X(W_X), .W_Y(W_Y)) bus ();

   mlp_98_frame_feeder #(
      .N1      (N1),
      .W_X     (W_X),
      .W_Y     (W_Y),
      .LATENCY (LAT)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .in_mag  (in_mag),
      .in_pol  (in_pol),
      .mlp_out (mlp_out),
      .err     (err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int idx      = 0;
   logic [W_X-1:0] exp_mag [NS];
   logic           exp_pol [NS];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS*W_X-1:0] exp_mag_vec();
      logic [NS*W_X-1:0] v;
      for (int i = 0; i < NS; i++) v[i*W_X +: W_X] = exp_mag[i];
      return v;
   endfunction

   function automatic logic [NS-1:0] exp_pol_vec();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = exp_pol[i];
      return v;
   endfunction

   function automatic logic [W_X-1:0] pat_mag(input int kind, input int k);
      case (kind)
         0:       return 4'(k % 16);
         1:       return 4'((3 * k + 1) % 16);
         2:       return 4'((7 * k + 5) % 16);
         default: return 4'(15 - (k % 16));
      endcase
   endfunction

   function automatic logic pat_pol(input int kind, input int k);
      logic [31:0] kk;
      kk = 32'(k);
      case (kind)
         0:       return kk[0];
         1:       return !kk[0];
         2:       return kk[1];
         default: return kk[2];
      endcase
   endfunction

   // Drive one sample and hold it until accepted; the model lane is updated on the accepting edge.
   task automatic send(input logic [W_X-1:0] mag, input logic pol, input logic last,
                       input bit gap);
      int n;
      n = 0;
      while (gap && n < 8 && ($urandom_range(0, 1) == 1)) begin
         bus.s_valid = 1'b0;
         bus.s_mag   = 4'($urandom);
         bus.s_pol   = 1'($urandom);
         bus.s_last  = 1'($urandom);
         tick();
         n++;
      end
      bus.s_valid = 1'b1;
      bus.s_mag   = mag;
      bus.s_pol   = pol;
      bus.s_last  = last;
      n = 0;
      while (!bus.s_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $error("FAIL s_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      exp_mag[idx] = mag;
      exp_pol[idx] = pol;
      if (last || idx == NS - 1) idx = 0;
      else idx++;
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic send_frame(input int kind, input bit last48, input bit gap);
      for (int k = 0; k < NS; k++)
         send(pat_mag(kind, k), pat_pol(kind, k), (k == NS - 1) && last48, gap);
   endtask

   // Called just after the edge that accepted the final sample.
   task automatic expect_result(input string tag, input logic [W_Y-1:0] val, input bit exp_err);
      int   cnt;
      logic extra_err;
      chk({tag, "_err_pulse"}, 256'(err), 256'(exp_err));
      chk({tag, "_s_ready_low"}, 256'(bus.s_ready), 256'(0));
      chk({tag, "_in_mag"}, 256'(in_mag), 256'(exp_mag_vec()));
      chk({tag, "_in_pol"}, 256'(in_pol), 256'(exp_pol_vec()));
      cnt       = 0;
      extra_err = 1'b0;
      while (!bus.m_valid && cnt < 40) begin
         tick();
         cnt++;
         extra_err |= err;
      end
      chk({tag, "_latency"}, 256'(cnt), 256'(LAT));
      chk({tag, "_err_after"}, 256'(extra_err), 256'(0));
      chk({tag, "_m_data"}, 256'(bus.m_data), 256'(val));
   endtask

   // m_ready is high: the next edge completes the handshake.
   task automatic expect_handshake(input string tag, input logic [W_Y-1:0] val);
      tick();
      chk({tag, "_m_valid_drop"}, 256'(bus.m_valid), 256'(0));
      chk({tag, "_s_ready_back"}, 256'(bus.s_ready), 256'(1));
      chk({tag, "_m_data_kept"}, 256'(bus.m_data), 256'(val));
   endtask

   initial begin
      logic stable;
      logic seen_valid;

      for (int i = 0; i < NS; i++) begin
         exp_mag[i] = '0;
         exp_pol[i] = 1'b0;
      end
      bus.s_valid = 1'b0;
      bus.s_mag   = '0;
      bus.s_pol   = 1'b0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;
      mlp_out     = 23'h1A2B3C;

      // Reset values
      #1 rstn = 1'b0;
      #3;
      chk("rst_s_ready", 256'(bus.s_ready), 256'(0));
      chk("rst_in_mag", 256'(in_mag), 256'(0));
      chk("rst_in_pol", 256'(in_pol), 256'(0));
      chk("rst_m_valid", 256'(bus.m_valid), 256'(0));
      chk("rst_m_data", 256'(bus.m_data), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      tick();
      tick();
      rstn = 1'b1;
      tick();
      chk("post_rst_s_ready", 256'(bus.s_ready), 256'(1));

      // 1: normal frame
      send_frame(0, 1'b1, 1'b0);
      expect_result("t1", 23'h1A2B3C, 1'b0);
      expect_handshake("t1", 23'h1A2B3C);

      // 2: backpressure; input and core result wiggle while the result is held
      bus.m_ready = 1'b0;
      mlp_out     = 23'h055AA1;
      send_frame(1, 1'b1, 1'b0);
      expect_result("t2", 23'h055AA1, 1'b0);
      mlp_out     = 23'h7FFFFF;
      bus.s_valid = 1'b1;
      bus.s_mag   = 4'hF;
      bus.s_pol   = 1'b1;
      bus.s_last  = 1'b1;
      stable      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!(bus.m_valid === 1'b1 && bus.m_data === 23'h055AA1 && bus.s_ready === 1'b0 &&
               err === 1'b0)) stable = 1'b0;
      end
      chk("t2_hold_stable", 256'(stable), 256'(1));
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      chk("t2_frame_held", 256'(in_mag), 256'(exp_mag_vec()));
      bus.m_ready = 1'b1;
      expect_handshake("t2", 23'h055AA1);

      // 3: early s_last on the 10th sample
      for (int k = 0; k < 10; k++) send(pat_mag(2, k), pat_pol(2, k), k == 9, 1'b0);
      chk("t3_err_pulse", 256'(err), 256'(1));
      chk("t3_partial_mag", 256'(in_mag), 256'(exp_mag_vec()));
      chk("t3_partial_pol", 256'(in_pol), 256'(exp_pol_vec()));
      tick();
      chk("t3_err_clear", 256'(err), 256'(0));
      seen_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen_valid |= bus.m_valid;
      end
      chk("t3_no_result", 256'(seen_valid), 256'(0));
      chk("t3_s_ready", 256'(bus.s_ready), 256'(1));
      mlp_out = 23'h2C0FFE;
      send_frame(3, 1'b1, 1'b0);
      expect_result("t3", 23'h2C0FFE, 1'b0);
      expect_handshake("t3", 23'h2C0FFE);

      // 4: missing s_last
      mlp_out = 23'h013579;
      send_frame(0, 1'b0, 1'b0);
      expect_result("t4", 23'h013579, 1'b1);
      expect_handshake("t4", 23'h013579);

      // 5: gapped input
      mlp_out = 23'h6A5A5A;
      send_frame(2, 1'b1, 1'b1);
      expect_result("t5", 23'h6A5A5A, 1'b0);
      expect_handshake("t5", 23'h6A5A5A);

      // 6: reset five cycles into WAIT
      mlp_out = 23'h111111;
      send_frame(1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      rstn = 1'b0;
      #1;
      chk("t6_rst_in_mag", 256'(in_mag), 256'(0));
      chk("t6_rst_in_pol", 256'(in_pol), 256'(0));
      chk("t6_rst_m_valid", 256'(bus.m_valid), 256'(0));
      chk("t6_rst_m_data", 256'(bus.m_data), 256'(0));
      chk("t6_rst_s_ready", 256'(bus.s_ready), 256'(0));
      tick();
      tick();
      rstn = 1'b1;
      for (int i = 0; i < NS; i++) begin
         exp_mag[i] = '0;
         exp_pol[i] = 1'b0;
      end
      idx = 0;
      tick();
      chk("t6_s_ready", 256'(bus.s_ready), 256'(1));
      seen_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen_valid |= bus.m_valid;
      end
      chk("t6_no_result", 256'(seen_valid), 256'(0));
      mlp_out = 23'h3ABCDE;
      send_frame(3, 1'b1, 1'b0);
      expect_result("t6", 23'h3ABCDE, 1'b0);
      expect_handshake("t6", 23'h3ABCDE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
